// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: retire/CSR redirect inputs, imem address/data, decode-side outputs.
// Latency: none (wires only).
// Backpressure: hold_i from decode stalls the fetch stage.
// Optional macro BRANCH_PREDICTION_EN adds the predicted_branch_o signal.
// Modports: master = fetch unit side, slave = environment side (retire, CSR, imem, decode).
interface fetch_unit_if;
  logic        hold_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        ctx_switch_i;
  logic [31:0] ctx_switch_target_i;
  logic [31:0] instruction_address_o;
  logic [31:0] instruction_data_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic [2:0]  tag_o;
  logic        valid_o;
  logic        exc_misaligned_fetch_o;
`ifdef BRANCH_PREDICTION_EN
  logic        predicted_branch_o;
`endif

  modport master (
    input  hold_i, jump_i, jump_target_i, ctx_switch_i, ctx_switch_target_i,
    input  instruction_data_i,
    output instruction_address_o, instruction_o, pc_o, tag_o, valid_o,
`ifdef BRANCH_PREDICTION_EN
    output predicted_branch_o,
`endif
    output exc_misaligned_fetch_o
  );

  modport slave (
    output hold_i, jump_i, jump_target_i, ctx_switch_i, ctx_switch_target_i,
    output instruction_data_i,
    input  instruction_address_o, instruction_o, pc_o, tag_o, valid_o,
`ifdef BRANCH_PREDICTION_EN
    input  predicted_branch_o,
`endif
    input  exc_misaligned_fetch_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: issues imem addresses, pairs returned words with PC/path tag, delivers to decode.
// Latency: address at t, word on instruction_o at t+1; redirect at t -> target word at t+2.
// Backpressure: hold_i stops issue; the single in-flight word is parked in a one-entry skid.
// Ports: clk, reset (sync, active-high), bus (fetch_unit_if.master).
// Optional macro BRANCH_PREDICTION_EN: static backward-taken branch predictor + predicted_branch_o.
module fetch_unit #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP        = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  logic [31:0] pc_q;
  logic [2:0]  tag_q;

  logic        resp_valid_q;
  logic [31:0] resp_pc_q;
  logic [2:0]  resp_tag_q;
  logic        resp_mis_q;

  logic        skid_valid_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc_q;
  logic [2:0]  skid_tag_q;
  logic        skid_mis_q;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        issue;
  logic        predict;
  logic [31:0] predict_pc;

  logic        sel_valid;
  logic [31:0] sel_instr;
  logic [31:0] sel_pc;
  logic [2:0]  sel_tag;
  logic        sel_mis;

  assign redirect    = bus.jump_i | bus.ctx_switch_i;
  // CSR-originated redirects (trap/MRET) override retire jumps.
  assign redirect_pc = bus.ctx_switch_i ? bus.ctx_switch_target_i : bus.jump_target_i;
  assign issue       = !bus.hold_i && !redirect;

  // A parked skid word always takes precedence over the live imem response.
  always_comb begin
    sel_valid = resp_valid_q;
    sel_instr = bus.instruction_data_i;
    sel_pc    = resp_pc_q;
    sel_tag   = resp_tag_q;
    sel_mis   = resp_mis_q;
    if (skid_valid_q) begin
      sel_valid = 1'b1;
      sel_instr = skid_instr_q;
      sel_pc    = skid_pc_q;
      sel_tag   = skid_tag_q;
      sel_mis   = skid_mis_q;
    end
  end

  assign bus.instruction_address_o  = pc_q;
  assign bus.instruction_o          = sel_valid ? sel_instr : NOP;
  assign bus.pc_o                   = sel_pc;
  assign bus.tag_o                  = sel_tag;
  assign bus.valid_o                = sel_valid;
  assign bus.exc_misaligned_fetch_o = sel_mis;

`ifdef BRANCH_PREDICTION_EN
  logic [31:0] br_offset;

  // B-type immediate, sign-extended.
  assign br_offset  = {{19{sel_instr[31]}}, sel_instr[31], sel_instr[7],
                       sel_instr[30:25], sel_instr[11:8], 1'b0};
  // Only backward (negative offset) conditional branches are predicted taken,
  // and only when decode actually takes the word this cycle.
  assign predict    = !reset && sel_valid && !bus.hold_i && !redirect &&
                      (sel_instr[6:0] == 7'b1100011) && sel_instr[31];
  assign predict_pc = sel_pc + br_offset;
  assign bus.predicted_branch_o = predict;
`else
  assign predict    = 1'b0;
  assign predict_pc = 32'h0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= START_ADDR;
      tag_q        <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= 32'h0;
      resp_tag_q   <= 3'd0;
      resp_mis_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      skid_tag_q   <= 3'd0;
      skid_mis_q   <= 1'b0;
    end else if (redirect) begin
      // New path: bump the tag once and drop whatever is in flight or parked.
      pc_q         <= redirect_pc;
      tag_q        <= tag_q + 3'd1;
      resp_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (predict) begin
      // Same path, so the tag stays; the sequential word issued now is discarded.
      pc_q         <= predict_pc;
      resp_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (issue) begin
      // Any skid word is consumed this cycle while the next address goes out.
      pc_q         <= pc_q + 32'd4;
      resp_valid_q <= 1'b1;
      resp_pc_q    <= pc_q;
      resp_tag_q   <= tag_q;
      resp_mis_q   <= (pc_q[1:0] != 2'b00);
      skid_valid_q <= 1'b0;
    end else begin
      // Stalled: the imem word returning now would be lost, so park it.
      resp_valid_q <= 1'b0;
      if (resp_valid_q && !skid_valid_q) begin
        skid_valid_q <= 1'b1;
        skid_instr_q <= bus.instruction_data_i;
        skid_pc_q    <= resp_pc_q;
        skid_tag_q   <= resp_tag_q;
        skid_mis_q   <= resp_mis_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, imem model, scoreboard of delivered words.
// Latency: imem model answers one cycle after the address.
// Backpressure: hold_i driven by the stimulus; only accepted words are scoreboarded.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   failures = 0;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  tag;
    logic [31:0] instr;
    logic        mis;
    logic        pred;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
`ifdef BRANCH_PREDICTION_EN
    if (a == 32'h20) return 32'hFE0008E3;  // beq x0,x0,-16
`endif
    return {4'h5, a[27:0]};
  endfunction

  // Instruction memory: one-cycle read latency.
  initial bus.instruction_data_i = 32'h0;
  always @(posedge clk) bus.instruction_data_i <= mem_word(bus.instruction_address_o);

  task automatic push(input logic [31:0] pc, input logic [2:0] tag, input logic pred);
    exp_t e;
    e.pc    = pc;
    e.tag   = tag;
    e.instr = mem_word(pc);
    e.mis   = (pc[1:0] != 2'b00);
    e.pred  = pred;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: every word decode accepts is compared against the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.valid_o && !bus.hold_i) begin
      exp_t e;
      exp_t a;
      a.pc    = bus.pc_o;
      a.tag   = bus.tag_o;
      a.instr = bus.instruction_o;
      a.mis   = bus.exc_misaligned_fetch_o;
`ifdef BRANCH_PREDICTION_EN
      a.pred  = bus.predicted_branch_o;
`else
      a.pred  = 1'b0;
`endif
      tests++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL word_unexpected: got pc=%h tag=%0d, expected no word", a.pc, a.tag);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL word: got pc=%h tag=%0d instr=%h mis=%b pred=%b, expected pc=%h tag=%0d instr=%h mis=%b pred=%b",
                   a.pc, a.tag, a.instr, a.mis, a.pred, e.pc, e.tag, e.instr, e.mis, e.pred);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.hold_i = 1'b0;
    bus.jump_i = 1'b0;
    bus.jump_target_i = 32'h0;
    bus.ctx_switch_i = 1'b0;
    bus.ctx_switch_target_i = 32'h0;
    cyc();
    cyc();
    mid();
    chk("reset_addr", bus.instruction_address_o, 32'h0);
    chk("reset_valid", {31'h0, bus.valid_o}, 32'h0);
    chk("reset_instr_nop", bus.instruction_o, 32'h0000_0013);
`ifdef BRANCH_PREDICTION_EN
    chk("reset_pred", {31'h0, bus.predicted_branch_o}, 32'h0);
`endif

    // Sequential fetch, skid, first jump.
    push(32'h0, 3'd0, 1'b0);
    push(32'h4, 3'd0, 1'b0);
    push(32'h8, 3'd0, 1'b0);
    push(32'hC, 3'd0, 1'b0);
    push(32'h10, 3'd0, 1'b0);
    push(32'h100, 3'd1, 1'b0);
    push(32'h104, 3'd1, 1'b0);

    cyc(); reset = 1'b0; mid();                        // c0
    chk("c0_addr", bus.instruction_address_o, 32'h0);
    chk("c0_valid", {31'h0, bus.valid_o}, 32'h0);
    cyc();                                             // c1: pc 0
    cyc();                                             // c2: pc 4
    cyc(); bus.hold_i = 1'b1; mid();                   // c3: pc 8 held
    chk("hold_valid", {31'h0, bus.valid_o}, 32'h1);
    chk("hold_pc", bus.pc_o, 32'h8);
    chk("hold_addr", bus.instruction_address_o, 32'hC);
    cyc(); mid();                                      // c4: from skid
    chk("skid_pc", bus.pc_o, 32'h8);
    chk("skid_instr", bus.instruction_o, mem_word(32'h8));
    chk("skid_addr", bus.instruction_address_o, 32'hC);
    cyc();                                             // c5
    cyc(); bus.hold_i = 1'b0; mid();                   // c6: skid consumed
    chk("release_addr", bus.instruction_address_o, 32'hC);
    cyc();                                             // c7: pc C
    cyc(); bus.jump_i = 1'b1; bus.jump_target_i = 32'h100;  // c8: pc 10
    cyc(); bus.jump_i = 1'b0; mid();                   // c9
    chk("jump_addr", bus.instruction_address_o, 32'h100);
    chk("jump_bubble_valid", {31'h0, bus.valid_o}, 32'h0);
    chk("jump_bubble_nop", bus.instruction_o, 32'h0000_0013);
    cyc();                                             // c10: pc 100 tag 1

    // Six back-to-back redirects take the tag from 1 to 7.
    cyc(); bus.jump_i = 1'b1; bus.jump_target_i = 32'h200;  // c11: pc 104
    repeat (5) cyc();                                  // c12..c16
    cyc(); bus.jump_i = 1'b0; mid();                   // c17
    chk("multi_jump_addr", bus.instruction_address_o, 32'h200);
    push(32'h200, 3'd7, 1'b0);
    cyc();                                             // c18: pc 200 tag 7
    cyc(); bus.hold_i = 1'b1;                          // c19: pc 204 held
    cyc(); bus.jump_i = 1'b1; bus.ctx_switch_i = 1'b1;
    bus.jump_target_i = 32'h300; bus.ctx_switch_target_i = 32'h80; mid();  // c20
    chk("both_skid_pc", bus.pc_o, 32'h204);
    chk("both_skid_tag", {29'h0, bus.tag_o}, 32'h7);
    push(32'h80, 3'd0, 1'b0);
    push(32'h84, 3'd0, 1'b0);
    cyc(); bus.hold_i = 1'b0; bus.jump_i = 1'b0; bus.ctx_switch_i = 1'b0; mid();  // c21
    chk("ctx_addr", bus.instruction_address_o, 32'h80);
    chk("ctx_skid_cleared", {31'h0, bus.valid_o}, 32'h0);
    cyc();                                             // c22: pc 80 tag 0

    // Misaligned target.
    push(32'h102, 3'd1, 1'b0);
    push(32'h106, 3'd1, 1'b0);
    push(32'h10A, 3'd1, 1'b0);
    cyc(); bus.jump_i = 1'b1; bus.jump_target_i = 32'h102;  // c23: pc 84
    cyc(); bus.jump_i = 1'b0;                          // c24
    cyc(); mid();                                      // c25: pc 102
    chk("mis_exc", {31'h0, bus.exc_misaligned_fetch_o}, 32'h1);
    cyc();                                             // c26: pc 106
    push(32'h40, 3'd2, 1'b0);
    push(32'h44, 3'd2, 1'b0);
    cyc(); bus.jump_i = 1'b1; bus.jump_target_i = 32'h40;   // c27: pc 10A
    cyc(); bus.jump_i = 1'b0;                          // c28
    cyc();                                             // c29: pc 40

    // Run through 0x20 (a backward branch when prediction is built in).
    push(32'h18, 3'd3, 1'b0);
    push(32'h1C, 3'd3, 1'b0);
`ifdef BRANCH_PREDICTION_EN
    push(32'h20, 3'd3, 1'b1);
    push(32'h10, 3'd3, 1'b0);
`else
    push(32'h20, 3'd3, 1'b0);
    push(32'h24, 3'd3, 1'b0);
    push(32'h28, 3'd3, 1'b0);
`endif
    cyc(); bus.jump_i = 1'b1; bus.jump_target_i = 32'h18;   // c30: pc 44
    cyc(); bus.jump_i = 1'b0;                          // c31
    cyc();                                             // c32: pc 18
    cyc();                                             // c33: pc 1C
    cyc();                                             // c34: pc 20
    cyc(); mid();                                      // c35
`ifdef BRANCH_PREDICTION_EN
    chk("pred_squash_valid", {31'h0, bus.valid_o}, 32'h0);
    chk("pred_target_addr", bus.instruction_address_o, 32'h10);
`else
    chk("seq_after_20_pc", bus.pc_o, 32'h24);
`endif
    cyc();                                             // c36

    // Reset with a word in flight.
    push(32'h0, 3'd0, 1'b0);
    push(32'h4, 3'd0, 1'b0);
    cyc(); reset = 1'b1;                               // c37
    cyc(); reset = 1'b0; mid();                        // c38
    chk("rst_mid_valid", {31'h0, bus.valid_o}, 32'h0);
    chk("rst_mid_addr", bus.instruction_address_o, 32'h0);
    cyc();                                             // c39: pc 0
    cyc();                                             // c40: pc 4
    cyc(); bus.hold_i = 1'b1; mid();                   // c41
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
